// File: rtl/key_event_queue.sv
// Classifies 4 key-press flag streams into single/double-click events and queues them
// in a first-word-fall-through FIFO read through a valid/ready handshake.
module key_event_queue #(
    parameter int DBL_WIN    = 25_000_000,
    parameter int TW         = 25,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    key_flag,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [1:0]    evt_key,
    output logic          evt_double,
    output logic [LW-1:0] evt_level,
    output logic          overflow
);
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WAIT2 = 1'b1
    } key_state_e;

    // Per-key click window state, kept as named arrays so checkers can bind to them.
    key_state_e    state_q [4];
    key_state_e    state_d [4];
    logic [TW-1:0] timer_q [4];
    logic [TW-1:0] timer_d [4];
    logic [3:0]    raise;
    logic [3:0]    raise_dbl;

    logic [3:0]    pend_q, pend_d;
    logic [3:0]    pdbl_q, pdbl_d;
    logic [3:0]    grant;
    logic [3:0]    collide;
    logic          push_req;
    logic [1:0]    push_key;
    logic          push_dbl;

    logic [FIFO_DEPTH-1:0][1:0] mem_key_q;
    logic [FIFO_DEPTH-1:0]      mem_dbl_q;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i]   = state_q[i];
            timer_d[i]   = timer_q[i];
            raise[i]     = 1'b0;
            raise_dbl[i] = 1'b0;
            case (state_q[i])
                S_IDLE: begin
                    if (key_flag[i]) begin
                        state_d[i] = S_WAIT2;
                        timer_d[i] = TW'(DBL_WIN - 1);
                    end
                end
                S_WAIT2: begin
                    // A second press wins over a window expiring in the same cycle.
                    if (key_flag[i]) begin
                        raise[i]     = 1'b1;
                        raise_dbl[i] = 1'b1;
                        state_d[i]   = S_IDLE;
                    end else if (timer_q[i] == '0) begin
                        raise[i]   = 1'b1;
                        state_d[i] = S_IDLE;
                    end else begin
                        timer_d[i] = timer_q[i] - TW'(1);
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // Fixed priority: the lowest pending key index is offered to the FIFO each cycle.
    always_comb begin
        grant    = '0;
        push_key = 2'd0;
        push_dbl = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) begin
                grant    = 4'b0001 << i;
                push_key = 2'(i);
                push_dbl = pdbl_q[i];
            end
        end
    end

    assign push_req = |pend_q;

    always_comb begin
        collide = '0;
        pend_d  = pend_q & ~grant;
        pdbl_d  = pdbl_q;
        for (int i = 0; i < 4; i++) begin
            if (raise[i]) begin
                if (pend_d[i]) begin
                    collide[i] = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    pdbl_d[i] = raise_dbl[i];
                end
            end
        end
    end

    // Handshake: the head entry is presented while evt_valid=1 and stays unchanged until the
    // cycle in which evt_ready=1 is seen with it; evt_ready is ignored while the FIFO is empty.
    assign full      = (count_q == LW'(FIFO_DEPTH));
    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid & evt_ready;
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_comb begin
        wptr_d     = wptr_q + AW'(push_ok);
        rptr_d     = rptr_q + AW'(pop);
        count_d    = count_q;
        overflow_d = overflow_q | drop | (|collide);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= S_IDLE;
                timer_q[i] <= '0;
            end
            pend_q     <= '0;
            pdbl_q     <= '0;
            mem_key_q  <= '0;
            mem_dbl_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            pend_q <= pend_d;
            pdbl_q <= pdbl_d;
            if (push_ok) begin
                mem_key_q[wptr_q] <= push_key;
                mem_dbl_q[wptr_q] <= push_dbl;
            end
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign evt_key    = evt_valid ? mem_key_q[rptr_q] : 2'd0;
    assign evt_double = evt_valid ? mem_dbl_q[rptr_q] : 1'b0;
    assign evt_level  = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed latency/ordering scenarios plus random key traffic,
// every cycle compared against a timestamp-based click model and an expected-event queue.
module tb_key_event_queue;
    localparam int DBL_WIN = 8;
    localparam int TW      = 8;
    localparam int DEPTH   = 4;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    key_flag;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_key;
    logic          evt_double;
    logic [LW-1:0] evt_level;
    logic          overflow;

    key_event_queue #(
        .DBL_WIN    (DBL_WIN),
        .TW         (TW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_flag   (key_flag),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_key    (evt_key),
        .evt_double (evt_double),
        .evt_level  (evt_level),
        .overflow   (overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state: expected FIFO contents {key, double}, head first
    logic [2:0] exp_q[$];
    int         open_at [4];
    bit         pend [4];
    bit         pdbl [4];
    bit         m_ovf;
    bit         known;
    bit         just_reset;
    int         cyc;

    int         n_vec;
    int         n_err;

    logic          obs_valid;
    logic [1:0]    obs_key;
    logic          obs_dbl;
    logic [LW-1:0] obs_level;
    logic          obs_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: a press opens a window at cycle p; a press in p+1..p+DBL_WIN makes a double,
    // otherwise a single is raised at the end of cycle p+DBL_WIN.
    task automatic ref_tick(input logic [3:0] f, input logic r, input logic rn);
        bit was_full;
        bit do_pop;
        bit have_push;
        int pk;
        bit pdk;
        bit raised;
        bit dbl;
        just_reset = 1'b0;
        if (!rn) begin
            exp_q.delete();
            m_ovf = 1'b0;
            for (int k = 0; k < 4; k++) begin
                open_at[k] = -1;
                pend[k]    = 1'b0;
                pdbl[k]    = 1'b0;
            end
            just_reset = 1'b1;
            known      = 1'b1;
            return;
        end
        was_full  = (exp_q.size() == DEPTH);
        do_pop    = (exp_q.size() != 0) && (r == 1'b1);
        have_push = 1'b0;
        pk        = 0;
        pdk       = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (pend[k] && !have_push) begin
                have_push = 1'b1;
                pk        = k;
                pdk       = pdbl[k];
                pend[k]   = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            raised = 1'b0;
            dbl    = 1'b0;
            if (open_at[k] >= 0) begin
                if (f[k]) begin
                    raised = 1'b1;
                    dbl    = 1'b1;
                end else if (cyc - open_at[k] == DBL_WIN) begin
                    raised = 1'b1;
                end
            end else if (f[k]) begin
                open_at[k] = cyc;
            end
            if (raised) begin
                open_at[k] = -1;
                if (pend[k]) m_ovf = 1'b1;
                else begin
                    pend[k] = 1'b1;
                    pdbl[k] = dbl;
                end
            end
        end
        if (do_pop) void'(exp_q.pop_front());
        if (have_push) begin
            if (!was_full || do_pop) exp_q.push_back({2'(pk), pdk});
            else m_ovf = 1'b1;
        end
    endtask

    // driver: one clock cycle of stimulus, outputs compared mid-cycle, model advanced at the edge
    task automatic step(input logic [3:0] f, input logic r, input logic rn);
        key_flag  = f;
        evt_ready = r;
        rst_n     = rn;
        @(negedge clk);
        obs_valid = evt_valid;
        obs_key   = evt_key;
        obs_dbl   = evt_double;
        obs_level = evt_level;
        obs_ovf   = overflow;
        if (known) begin
            check("valid", evt_valid, exp_q.size() != 0);
            check("level", evt_level, exp_q.size());
            check("ovf", overflow, m_ovf);
            if (exp_q.size() != 0) begin
                check("key", evt_key, exp_q[0][2:1]);
                check("dbl", evt_double, exp_q[0][0]);
            end
            if (just_reset) begin
                check("rst_key", evt_key, 0);
                check("rst_dbl", evt_double, 0);
            end
        end
        @(posedge clk);
        ref_tick(f, r, rn);
        cyc++;
        #1;
    endtask

    task automatic idle_watch(input int n, input int base, output int first, output int cnt,
                              output logic [1:0] fk, output logic fd);
        first = -1;
        cnt   = 0;
        fk    = 2'd0;
        fd    = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(4'b0000, 1'b1, 1'b1);
            if (obs_valid === 1'b1) begin
                if (first < 0) begin
                    first = base + i;
                    fk    = obs_key;
                    fd    = obs_dbl;
                end
                cnt++;
            end
        end
    endtask

    task automatic drain(input int n, output int got_n, output logic [1:0] keys [8],
                         output logic dbls [8]);
        got_n = 0;
        for (int i = 0; i < 8; i++) begin
            keys[i] = 2'd0;
            dbls[i] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            step(4'b0000, 1'b1, 1'b1);
            if (obs_valid === 1'b1 && got_n < 8) begin
                keys[got_n] = obs_key;
                dbls[got_n] = obs_dbl;
                got_n++;
            end
        end
    endtask

    initial begin
        int         first;
        int         cnt;
        int         got_n;
        logic [1:0] fk;
        logic       fd;
        logic [1:0] keys [8];
        logic       dbls [8];
        logic [3:0] f;

        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        known = 1'b0;
        just_reset = 1'b0;
        key_flag  = 4'b0000;
        evt_ready = 1'b0;
        rst_n     = 1'b0;

        // reset, then idle
        step(4'b0000, 1'b0, 1'b0);
        idle_watch(20, 0, first, cnt, fk, fd);
        check("t1_cnt", cnt, 0);
        check("t1_ovf", obs_ovf, 0);

        // single click on key 0
        step(4'b0001, 1'b1, 1'b1);
        idle_watch(20, 1, first, cnt, fk, fd);
        check("t2_first", first, DBL_WIN + 2);
        check("t2_cnt", cnt, 1);
        check("t2_key", fk, 0);
        check("t2_dbl", fd, 0);

        // double click on key 2, pulses 5 cycles apart
        step(4'b0100, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b1);
        step(4'b0100, 1'b1, 1'b1);
        idle_watch(20, 6, first, cnt, fk, fd);
        check("t3_first", first, 7);
        check("t3_cnt", cnt, 1);
        check("t3_key", fk, 2);
        check("t3_dbl", fd, 1);

        // second press exactly as the window expires still counts as a double
        step(4'b0001, 1'b1, 1'b1);
        for (int i = 0; i < DBL_WIN - 1; i++) step(4'b0000, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        idle_watch(20, DBL_WIN + 1, first, cnt, fk, fd);
        check("t4_first", first, DBL_WIN + 2);
        check("t4_cnt", cnt, 1);
        check("t4_dbl", fd, 1);

        // all four keys at once, consumer stalled, then overflow
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) step(4'b0000, 1'b0, 1'b1);
        check("t5_lvl", obs_level, 4);
        check("t5_ovf", obs_ovf, 0);
        step(4'b0001, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0001, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b1);
        check("t5_ovf2", obs_ovf, 1);
        check("t5_lvl2", obs_level, 4);
        drain(8, got_n, keys, dbls);
        check("t5_n", got_n, 4);
        for (int i = 0; i < 4; i++) begin
            check("t5_order", keys[i], i);
            check("t5_single", dbls[i], 0);
        end

        // full FIFO, push and pop in the same cycle
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) step(4'b0000, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        check("t6_lvl", obs_level, 4);
        check("t6_ovf", obs_ovf, 0);
        drain(8, got_n, keys, dbls);
        check("t6_n", got_n, 4);
        check("t6_last_key", keys[3], 1);
        check("t6_last_dbl", dbls[3], 1);

        // reset in the middle of a window discards the click
        step(4'b0001, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b0);
        idle_watch(20, 0, first, cnt, fk, fd);
        check("t6_rst_cnt", cnt, 0);

        // random traffic with varying press density and back-pressure
        for (int seg = 0; seg < 6; seg++) begin
            int dens;
            dens = $urandom_range(3, 14);
            for (int i = 0; i < 120; i++) begin
                for (int b = 0; b < 4; b++) f[b] = ($urandom_range(0, dens - 1) == 0);
                step(f, $urandom_range(0, 2) != 0, $urandom_range(0, 199) != 0);
            end
        end
        for (int i = 0; i < 30; i++) step(4'b0000, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
